// File: rtl/alarm_zone_ctrl_pkg.sv
// Shared types and constants for the zoned alarm controller.
// State encodings are fixed here so keypad/status logic can decode the state bus.
package alarm_zone_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4,
        S_SILENCED  = 3'd5
    } state_t;

    // Doors occupy the low bits of the zone vector, windows sit above them.
    localparam int DOOR_BASE = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_zone_ctrl_if.sv
// Sensor/keypad/siren bundle between the alarm controller and its surroundings.
interface alarm_zone_ctrl_if
    import alarm_zone_ctrl_pkg::*;
#(
    parameter int N_DOORS   = 2,
    parameter int N_WINDOWS = 3
);
    logic                           arm_req;
    logic                           disarm_req;
    logic                           stay_mode;
    logic [N_DOORS-1:0]             doors;
    logic [N_WINDOWS-1:0]           windows;
    logic                           armed;
    logic                           secure;
    logic                           alarm;
    logic [STATE_W-1:0]             state;
    logic [N_DOORS+N_WINDOWS-1:0]   tripped;

    modport master (
        output arm_req, disarm_req, stay_mode, doors, windows,
        input  armed, secure, alarm, state, tripped
    );

    modport slave (
        input  arm_req, disarm_req, stay_mode, doors, windows,
        output armed, secure, alarm, state, tripped
    );
endinterface

// File: rtl/alarm_zone_ctrl_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module alarm_zone_ctrl_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    output logic         done
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);
endmodule

// File: rtl/alarm_zone_ctrl.sv
// Zoned alarm controller: arming modes, exit/entry delays, time-limited siren
// and a sticky per-zone trip record. All outputs come straight from flops.
module alarm_zone_ctrl
    import alarm_zone_ctrl_pkg::*;
#(
    parameter int N_DOORS      = 2,
    parameter int N_WINDOWS    = 3,
    parameter int EXIT_CYCLES  = 16,
    parameter int ENTRY_CYCLES = 16,
    parameter int SIREN_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    alarm_zone_ctrl_if.slave bus
);
    localparam int N_ZONES = N_DOORS + N_WINDOWS;
    localparam int TW      = $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES) + 1);

    // Timer is loaded with N-1 so the state is held for exactly N clocks.
    localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYCLES - 1);
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYCLES - 1);
    localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYCLES - 1);

    state_t               state_reg, state_next;
    logic                 mode_reg, mode_next;
    logic [N_ZONES-1:0]   tripped_reg, tripped_next;
    logic                 armed_reg, secure_reg, alarm_reg;

    logic [N_ZONES-1:0]   zones;
    logic [N_ZONES-1:0]   new_trips;
    logic                 any_door, any_window;
    logic                 tmr_load, tmr_clear, tmr_done;
    logic [TW-1:0]        tmr_val;

    assign zones      = {bus.windows, bus.doors};
    assign new_trips  = zones & ~tripped_reg;
    assign any_door   = |zones[DOOR_BASE +: N_DOORS];
    assign any_window = |bus.windows;

    alarm_zone_ctrl_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clear    (tmr_clear),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_DISARMED;
            mode_reg    <= 1'b0;
            tripped_reg <= '0;
            armed_reg   <= 1'b0;
            secure_reg  <= 1'b0;
            alarm_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            tripped_reg <= tripped_next;
            armed_reg   <= (state_next != S_DISARMED);
            secure_reg  <= (state_next == S_ARMED);
            alarm_reg   <= (state_next == S_ALARM);
        end
    end

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        tripped_next = tripped_reg;
        tmr_load     = 1'b0;
        tmr_clear    = 1'b0;
        tmr_val      = '0;

        if (state_reg == S_DISARMED) begin
            // A simultaneous disarm cancels the arm; an open window blocks arming.
            if (bus.arm_req && !bus.disarm_req && !any_window) begin
                state_next   = S_EXIT_DLY;
                mode_next    = bus.stay_mode;
                tripped_next = '0;
                tmr_load     = 1'b1;
                tmr_val      = EXIT_LOAD;
            end
        end else if (bus.disarm_req) begin
            state_next = S_DISARMED;
            tmr_clear  = 1'b1;
        end else begin
            case (state_reg)
                S_EXIT_DLY: begin
                    if (tmr_done) state_next = S_ARMED;
                end
                S_ARMED: begin
                    if (any_window || (any_door && mode_reg)) begin
                        state_next   = S_ALARM;
                        tripped_next = tripped_reg | zones;
                        tmr_load     = 1'b1;
                        tmr_val      = SIREN_LOAD;
                    end else if (any_door) begin
                        state_next   = S_ENTRY_DLY;
                        tripped_next = tripped_reg | zones;
                        tmr_load     = 1'b1;
                        tmr_val      = ENTRY_LOAD;
                    end
                end
                S_ENTRY_DLY: begin
                    if (any_window) begin
                        state_next   = S_ALARM;
                        tripped_next = tripped_reg | zones;
                        tmr_load     = 1'b1;
                        tmr_val      = SIREN_LOAD;
                    end else if (tmr_done) begin
                        state_next = S_ALARM;
                        tmr_load   = 1'b1;
                        tmr_val    = SIREN_LOAD;
                    end
                end
                S_ALARM: begin
                    if (tmr_done) state_next = S_SILENCED;
                end
                S_SILENCED: begin
                    // Zones already on record stay quiet even if held open.
                    if (new_trips != '0) begin
                        state_next   = S_ALARM;
                        tripped_next = tripped_reg | new_trips;
                        tmr_load     = 1'b1;
                        tmr_val      = SIREN_LOAD;
                    end
                end
                default: state_next = S_DISARMED;
            endcase
        end
    end

    assign bus.state   = state_reg;
    assign bus.armed   = armed_reg;
    assign bus.secure  = secure_reg;
    assign bus.alarm   = alarm_reg;
    assign bus.tripped = tripped_reg;
endmodule
